load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_unit.sv | 168 ++++++++++++++++
 tb/tb_load_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// Load unit: forms the effective address, issues one aligned memory read, then extracts and extends the addressed lane.
// Optional macro LOAD_MISALIGN_TRAP_EN: misaligned loads return an error instead of being truncated to the access size.

module load_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [11:0]     imm,
  input  logic [XLEN-1:0] rs1,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err
);

  localparam int OFFB = $clog2(XLEN / 8);
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic [OFFB-1:0] off_reg, off_next;
  logic [2:0]      funct3_reg, funct3_next;
  logic [XLEN-1:0] data_reg, data_next;
  logic            err_reg, err_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            ready_reg;

  logic [XLEN-1:0] ea;
  logic [OFFB-1:0] size_mask;
  logic [OFFB-1:0] lane_off;
  logic            illegal;
  logic            reject;

  // Request decode: effective address, access-size mask, legality.
  always_comb begin
    ea = rs1 + {{(XLEN-12){imm[11]}}, imm};
    case (funct3[1:0])
      2'd0:    size_mask = '0;
      2'd1:    size_mask = OFFB'(1);
      2'd2:    size_mask = OFFB'(3);
      default: size_mask = '1;
    endcase
    lane_off = ea[OFFB-1:0] & ~size_mask;
    illegal  = (opcode != OP_LOAD) || (funct3 == 3'd7) ||
               ((XLEN == 32) && ((funct3 == 3'd3) || (funct3 == 3'd6)));
`ifdef LOAD_MISALIGN_TRAP_EN
    reject = illegal || (|(ea[OFFB-1:0] & size_mask));
`else
    reject = illegal;
`endif
  end

  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] lane_up;
  logic [XLEN-1:0] load_data;
  logic [6:0]      drop;

  // Lane select, then left-justify and shift back to sign- or zero-extend.
  always_comb begin
    lane = mem_rdata >> {off_reg, 3'b000};
    case (funct3_reg[1:0])
      2'd0:    drop = 7'(XLEN - 8);
      2'd1:    drop = 7'(XLEN - 16);
      2'd2:    drop = 7'(XLEN - 32);
      default: drop = 7'd0;
    endcase
    lane_up = lane << drop;
    if (funct3_reg[2]) begin
      load_data = lane_up >> drop;
    end else begin
      load_data = $unsigned($signed(lane_up) >>> drop);
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    off_next    = off_reg;
    funct3_next = funct3_reg;
    data_next   = data_reg;
    err_next    = err_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid && ready_reg) begin
          addr_next   = {ea[XLEN-1:OFFB], {OFFB{1'b0}}};
          off_next    = lane_off;
          funct3_next = funct3;
          cnt_next    = '0;
          data_next   = '0;
          err_next    = reject;
          state_next  = reject ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          cnt_next   = '0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          data_next  = load_data;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          data_next  = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ready_reg stays low while in reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      off_reg    <= '0;
      funct3_reg <= '0;
      data_reg   <= '0;
      err_reg    <= 1'b0;
      cnt_reg    <= '0;
      ready_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      off_reg    <= off_next;
      funct3_reg <= funct3_next;
      data_reg   <= data_next;
      err_reg    <= err_next;
      cnt_reg    <= cnt_next;
      ready_reg  <= (state_next == IDLE);
    end
  end

  assign req_ready  = ready_reg;
  assign mem_req    = (state_reg == REQ);
  assign mem_addr   = mem_req ? addr_reg : '0;
  assign resp_valid = (state_reg == RESP);
  assign resp_data  = resp_valid ? data_reg : '0;
  assign resp_err   = resp_valid & err_reg;

endmodule

// File: tb/tb_load_unit.sv
// Directed testbench for load_unit (XLEN=32, TIMEOUT=16); misalign expectations follow LOAD_MISALIGN_TRAP_EN.

module tb_load_unit;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [11:0] imm;
  logic [31:0] rs1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  int n_cmp = 0;
  int n_err = 0;

  load_unit #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .funct3(funct3), .imm(imm), .rs1(rs1),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] im, input logic [31:0] base);
    req_valid = 1'b1;
    opcode    = op;
    funct3    = f3;
    imm       = im;
    rs1       = base;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; opcode = '0; funct3 = '0; imm = '0; rs1 = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; resp_ready = 1'b0;
    tick();
    tick();
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_data !== 32'h0) begin n_err++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
    n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    $display("reset: outputs cleared, req_ready=%b after release", req_ready);
  endtask

  task automatic test_lanes();
    logic [2:0]  f3_t   [6];
    logic [11:0] imm_t  [6];
    logic [31:0] rs1_t  [6];
    logic [31:0] rd_t   [6];
    logic [31:0] addr_t [6];
    logic [31:0] exp_t  [6];
    int          gd_t   [6];
    f3_t   = '{3'd0, 3'd5, 3'd1, 3'd2, 3'd4, 3'd0};
    imm_t  = '{12'h003, 12'hFFE, 12'hFFE, 12'h004, 12'h001, 12'h002};
    rs1_t  = '{32'h1000, 32'h2000, 32'h2000, 32'h3000, 32'h4000, 32'hFFFF_FFFF};
    rd_t   = '{32'h80FF_FFFF, 32'hBEEF_1234, 32'hBEEF_1234, 32'hDEAD_BEEF, 32'h1122_3344, 32'h0000_A500};
    addr_t = '{32'h1000, 32'h1FFC, 32'h1FFC, 32'h3004, 32'h4000, 32'h0000_0000};
    exp_t  = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_BEEF, 32'hDEAD_BEEF, 32'h0000_0033, 32'hFFFF_FFA5};
    gd_t   = '{0, 0, 0, 2, 1, 0};
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL lane%0d_ready: got %b want 1", i, req_ready); end
      issue(OP_LOAD, f3_t[i], imm_t[i], rs1_t[i]);
      for (int k = 0; k <= gd_t[i]; k++) begin
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL lane%0d_mem_req: got %b want 1", i, mem_req); end
        n_cmp++; if (mem_addr !== addr_t[i]) begin n_err++; $display("FAIL lane%0d_mem_addr: got %h want %h", i, mem_addr, addr_t[i]); end
        if (k < gd_t[i]) tick();
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL lane%0d_wait_valid: got %b want 0", i, resp_valid); end
      mem_rvalid = 1'b1;
      mem_rdata  = rd_t[i];
      tick();
      mem_rvalid = 1'b0;
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL lane%0d_resp_valid: got %b want 1", i, resp_valid); end
      n_cmp++; if (resp_data !== exp_t[i]) begin n_err++; $display("FAIL lane%0d_resp_data: got %h want %h", i, resp_data, exp_t[i]); end
      n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL lane%0d_resp_err: got %b want 0", i, resp_err); end
      $display("load f3=%0d rs1=%h imm=%h rdata=%h -> addr=%h data=%h err=%b", f3_t[i], rs1_t[i], imm_t[i], rd_t[i], addr_t[i], resp_data, resp_err);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL lane%0d_resp_drop: got %b want 0", i, resp_valid); end
    end
  endtask

  task automatic test_timeout();
    issue(OP_LOAD, 3'd2, 12'h000, 32'h5000);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL timeout_early%0d: got %b want 0", i, resp_valid); end
      tick();
    end
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL timeout_valid: got %b want 1", resp_valid); end
    n_cmp++; if (resp_err !== 1'b1) begin n_err++; $display("FAIL timeout_err: got %b want 1", resp_err); end
    n_cmp++; if (resp_data !== 32'h0) begin n_err++; $display("FAIL timeout_data: got %h want 0", resp_data); end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    n_cmp++; if (resp_data !== 32'h0) begin n_err++; $display("FAIL timeout_late_data: got %h want 0", resp_data); end
    n_cmp++; if (resp_err !== 1'b1) begin n_err++; $display("FAIL timeout_late_err: got %b want 1", resp_err); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL timeout_stale_valid: got %b want 0", resp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL timeout_stale_ready: got %b want 1", req_ready); end
    $display("timeout: lw 0x5000 no rvalid -> err=1 data=0 on cycle 17 after grant");
  endtask

  task automatic test_misalign();
    issue(OP_LOAD, 3'd2, 12'h002, 32'h1000);
`ifdef LOAD_MISALIGN_TRAP_EN
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL mis_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL mis_valid: got %b want 1", resp_valid); end
    n_cmp++; if (resp_err !== 1'b1) begin n_err++; $display("FAIL mis_err: got %b want 1", resp_err); end
    n_cmp++; if (resp_data !== 32'h0) begin n_err++; $display("FAIL mis_data: got %h want 0", resp_data); end
`else
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL mis_mem_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h1000) begin n_err++; $display("FAIL mis_mem_addr: got %h want 00001000", mem_addr); end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL mis_valid: got %b want 1", resp_valid); end
    n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL mis_err: got %b want 0", resp_err); end
    n_cmp++; if (resp_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL mis_data: got %h want cafef00d", resp_data); end
`endif
    $display("misalign: lw ea=0x1002 -> data=%h err=%b", resp_data, resp_err);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_illegal_stall();
    issue(OP_LOAD, 3'd3, 12'h000, 32'h1000);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL ill_valid%0d: got %b want 1", i, resp_valid); end
      n_cmp++; if (resp_err !== 1'b1) begin n_err++; $display("FAIL ill_err%0d: got %b want 1", i, resp_err); end
      n_cmp++; if (resp_data !== 32'h0) begin n_err++; $display("FAIL ill_data%0d: got %h want 0", i, resp_data); end
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL ill_ready%0d: got %b want 0", i, req_ready); end
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL ill_mem_req%0d: got %b want 0", i, mem_req); end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL ill_release: got %b want 0", resp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL ill_ready_after: got %b want 1", req_ready); end
    $display("illegal: funct3=3 -> err=1 held over 5-cycle stall, no mem_req");
    issue(7'b0100011, 3'd2, 12'h000, 32'h1000);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL badop_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (resp_err !== 1'b1) begin n_err++; $display("FAIL badop_err: got %b want 1", resp_err); end
    $display("illegal: opcode=0100011 -> err=%b", resp_err);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    issue(OP_LOAD, 3'd2, 12'h000, 32'h6000);
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rreq_mem_req: got %b want 1", mem_req); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rreq_async_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rreq_async_addr: got %h want 0", mem_addr); end
    tick();
    rst_n = 1'b1;
    tick();
    issue(OP_LOAD, 3'd2, 12'h000, 32'h6000);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rwait_ready: got %b want 0", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rwait_valid: got %b want 0", resp_valid); end
    tick();
    rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rwait_stale_valid: got %b want 0", resp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rwait_stale_ready: got %b want 1", req_ready); end
    tick();
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rwait_stale_later: got %b want 0", resp_valid); end
    $display("reset mid-op: load abandoned, stale rvalid ignored");
    issue(OP_LOAD, 3'd2, 12'h008, 32'h7000);
    n_cmp++; if (mem_addr !== 32'h7008) begin n_err++; $display("FAIL recover_addr: got %h want 00007008", mem_addr); end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BAD_F00D;
    tick();
    mem_rvalid = 1'b0;
    n_cmp++; if (resp_data !== 32'h0BAD_F00D) begin n_err++; $display("FAIL recover_data: got %h want 0badf00d", resp_data); end
    $display("recover: lw 0x7008 -> data=%h err=%b", resp_data, resp_err);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_timeout();
    test_misalign();
    test_illegal_stall();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
